mult_share_ctrl: RTL and testbench
==================================

MULT_SHARE_CTRL -- requirements
Module: mult_share_ctrl

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has operands pending.
REQ-005 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-006 req0_a, req0_b  input  8 each  requester 0 multiplicand, multiplier.
REQ-007 req1_valid, req1_ready, req1_a, req1_b  same as REQ-004..006, for requester 1.
REQ-008 rsp_valid  output  1  product available.
REQ-009 rsp_ready  input  1  consumer accepts product.
REQ-010 rsp_id  output  1  index of the requester that owns the product.
REQ-011 rsp_product  output  16  unsigned product a*b.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 reqN_ready SHALL be combinational: high only in IDLE, only for the granted requester, and only when that requester's valid is high.
REQ-015 Arbitration SHALL be round-robin: if one requester is valid, grant it; if both are valid, grant the requester not served last.
REQ-016 A handshake (valid && ready) at edge E SHALL latch a, b and id, clear the accumulator, set the bit counter to 0, update last-served, and enter RUN.
REQ-017 In RUN, each edge SHALL add (a << i) to the 16-bit accumulator when b[i]=1, then increment i.
REQ-018 After the edge that processes i=7, the FSM SHALL enter DONE, so rsp_valid is first high after edge E+8.
REQ-019 In DONE, rsp_valid, rsp_id and rsp_product SHALL be held stable until rsp_ready=1.
REQ-020 On rsp_ready=1 in DONE, the FSM SHALL go to IDLE; no request is accepted in that same cycle.
REQ-021 A requester arriving while busy=1 SHALL see ready=0 and SHALL hold its request; no request is dropped.
REQ-022 Arithmetic SHALL be unsigned with no overflow: 255*255=65025 fits in 16 bits.
REQ-023 Operand changes after acceptance SHALL NOT affect the in-flight product.

Reset
REQ-024 Reset SHALL force the following: state=IDLE, rsp_valid=0, rsp_id=0, rsp_product=0, busy=0, accumulator=0, counter=0, last-served=1 (requester 0 wins the first tie).
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation and discard the result; no response is produced for it.

Configuration
REQ-026 When MULT_EARLY_TERM_EN is defined, RUN SHALL exit to DONE as soon as the remaining multiplier bits b[7:i+1] are all zero, giving latency = (index of the MSB set in b) + 1, with a minimum of 1 edge (b=0 finishes after E+1).
REQ-027 Without MULT_EARLY_TERM_EN, latency SHALL be fixed at 8 RUN edges for every operand value.

Structure
REQ-028 Package mult_share_pkg SHALL hold the following: the FSM state typedef, OP_W=8, PROD_W=16, NUM_REQ=2, ITER_W=3.
REQ-029 The iterative datapath (accumulator, shifted operand, bit counter) SHALL be a sub-module, shift_add_core, with load/step/done controls; arbitration and the FSM stay in mult_share_ctrl.

Verification
REQ-030 Single request: req0 a=13, b=11, rsp_ready=1 -> rsp_valid after E+8; product=143; rsp_id=0.
REQ-031 Tie and rotation: both valid from reset with req0 (3,5) and req1 (7,9), held -> first response id=0, 15; second response id=1, 63.
REQ-032 Backpressure: a=255, b=255, rsp_ready=0 for 5 cycles -> product 65025 held stable; busy=1; req1 sees ready=0 throughout.
REQ-033 Reset mid-RUN: pulse reset at E+4 -> all outputs 0; state IDLE; no response for the aborted operation.
REQ-034 MULT_EARLY_TERM_EN: b=0x03, a=100 -> product 300 after E+2; b=0 -> product 0 after E+1; without the macro both take E+8.
REQ-035 Operand change: alter req0_a and req0_b after acceptance -> product matches the latched operands.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and sizing for the two-requester shift-add multiplier.
// Holds the controller FSM encoding and the operand/product/iteration widths.
package mult_share_pkg;
    localparam int OP_W    = 8;
    localparam int PROD_W  = 16;
    localparam int NUM_REQ = 2;
    localparam int ITER_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;
endpackage

// File: rtl/mult_share_ctrl_if.sv
// Request/response bundle between requesters, consumer and the shared multiplier.
// slave = multiplier side, master = requester/consumer side.
interface mult_share_ctrl_if;
    import mult_share_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_a;
    logic [OP_W-1:0]   req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_a;
    logic [OP_W-1:0]   req1_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [PROD_W-1:0] rsp_product;
    logic              busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_product, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_product, busy
    );
endinterface

// File: rtl/mult_share_ctrl_shift_add_core.sv
// Iterative shift-add datapath: one multiplier bit per step, 8 steps (fewer with MULT_EARLY_TERM_EN).
// No backpressure; o_done flags the step that completes the product.
module shift_add_core
    import mult_share_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [OP_W-1:0]   i_a,
    input  logic [OP_W-1:0]   i_b,
    output logic              o_done,
    output logic [PROD_W-1:0] o_product
);
    logic [PROD_W-1:0] r_acc;
    logic [PROD_W-1:0] r_a_sh;
    logic [OP_W-1:0]   r_b;
    logic [ITER_W-1:0] r_cnt;
    logic [PROD_W-1:0] w_addend;

    // r_b shifts right each step so bit 0 is always the current multiplier bit
    assign w_addend = r_b[0] ? r_a_sh : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc  <= '0;
            r_a_sh <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_acc  <= '0;
            r_a_sh <= {{(PROD_W-OP_W){1'b0}}, i_a};
            r_b    <= i_b;
            r_cnt  <= '0;
        end else if (i_step) begin
            r_acc  <= r_acc + w_addend;
            r_a_sh <= r_a_sh << 1;
            r_b    <= r_b >> 1;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

`ifdef MULT_EARLY_TERM_EN
    assign o_done = i_step && ((r_b[OP_W-1:1] == '0) || (r_cnt == ITER_W'(OP_W-1)));
`else
    assign o_done = i_step && (r_cnt == ITER_W'(OP_W-1));
`endif

    assign o_product = r_acc;
endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin shares one shift-add multiplier between two requesters; result after 8 RUN edges
// (MULT_EARLY_TERM_EN: MSB index of b + 1). Requests wait (ready=0) while busy; response held until rsp_ready.
module mult_share_ctrl
    import mult_share_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    mult_share_ctrl_if.slave bus
);
    state_t            r_state;
    state_t            w_next;
    req_id_t           r_last;
    req_id_t           r_id;
    req_id_t           w_gnt;
    logic              w_rdy0;
    logic              w_rdy1;
    logic              w_accept;
    logic              w_step;
    logic              w_done;
    logic              w_rsp_vld;
    logic              w_busy;
    logic [OP_W-1:0]   w_a;
    logic [OP_W-1:0]   w_b;
    logic [PROD_W-1:0] w_product;

    // On a tie the requester not served last wins; a lone requester always wins
    always_comb begin
        w_gnt = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_gnt = ~r_last;
        end else if (bus.req1_valid) begin
            w_gnt = 1'b1;
        end
    end

    assign w_a    = w_gnt ? bus.req1_a : bus.req0_a;
    assign w_b    = w_gnt ? bus.req1_b : bus.req0_b;
    assign w_step = (r_state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_last <= w_gnt;
                r_id   <= w_gnt;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_rdy0    = 1'b0;
        w_rdy1    = 1'b0;
        w_accept  = 1'b0;
        w_rsp_vld = 1'b0;
        w_busy    = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy   = 1'b0;
                w_rdy0   = bus.req0_valid && (w_gnt == 1'b0);
                w_rdy1   = bus.req1_valid && (w_gnt == 1'b1);
                w_accept = w_rdy0 || w_rdy1;
                if (w_accept) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_done) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_rsp_vld = 1'b1;
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    shift_add_core u_core (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_accept),
        .i_step    (w_step),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_done    (w_done),
        .o_product (w_product)
    );

    assign bus.req0_ready  = w_rdy0;
    assign bus.req1_ready  = w_rdy1;
    assign bus.rsp_valid   = w_rsp_vld;
    assign bus.rsp_id      = w_rsp_vld ? r_id : 1'b0;
    assign bus.rsp_product = w_rsp_vld ? w_product : '0;
    assign bus.busy        = w_busy;
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Randomized bench for mult_share_ctrl against a transaction-level round-robin/product model.
module tb_mult_share_ctrl;
    import mult_share_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_share_ctrl_if bus();

    mult_share_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int        n_chk = 0;
    int        n_fail = 0;
    bit        p_vld [2];
    logic [7:0] p_a  [2];
    logic [7:0] p_b  [2];
    int        last_srv;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

`ifdef MULT_EARLY_TERM_EN
    function automatic int early_lat(input logic [7:0] b);
        int lat = 1;
        for (int i = 0; i < 8; i++) if (b[i]) lat = i + 1;
        return lat;
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        bus.req0_valid = p_vld[0];
        bus.req0_a     = p_a[0];
        bus.req0_b     = p_b[0];
        bus.req1_valid = p_vld[1];
        bus.req1_a     = p_a[1];
        bus.req1_b     = p_b[1];
    endtask

    task automatic new_req(input int r);
        p_vld[r] = 1'b1;
        p_a[r]   = 8'($urandom);
        p_b[r]   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
    endtask

    // Runs one request from acceptance to response release; caller leaves DUT idle with >=1 pending
    task automatic do_txn(input int bp, input bit late);
        int w;
        int o;
        int n;
        int exp_lat;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [15:0] prod;
        drive();
        #1;
        if (p_vld[0] && p_vld[1]) w = 1 - last_srv;
        else w = p_vld[1] ? 1 : 0;
        o = 1 - w;
        check_val("ready0_idle", bus.req0_ready, (w == 0));
        check_val("ready1_idle", bus.req1_ready, (w == 1));
        check_val("busy_idle", bus.busy, 0);
        ea = p_a[w];
        eb = p_b[w];
        prod = 16'(int'(ea) * int'(eb));
`ifdef MULT_EARLY_TERM_EN
        exp_lat = early_lat(eb);
`else
        exp_lat = 8;
`endif
        tick();
        last_srv = w;
        p_vld[w] = 1'b0;
        p_a[w]   = 8'($urandom);
        p_b[w]   = 8'($urandom);
        if (late && !p_vld[o]) new_req(o);
        drive();
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (bus.rsp_valid) break;
            check_val("busy_run", bus.busy, 1);
            check_val("ready_run", {bus.req1_ready, bus.req0_ready}, 0);
        end
        check_val("latency", n, exp_lat);
        check_val("product", bus.rsp_product, prod);
        check_val("rsp_id", bus.rsp_id, w);
        check_val("busy_done", bus.busy, 1);
        for (int k = 0; k < bp; k++) begin
            tick();
            check_val("hold_valid", bus.rsp_valid, 1);
            check_val("hold_product", bus.rsp_product, prod);
            check_val("hold_id", bus.rsp_id, w);
            check_val("ready_hold", {bus.req1_ready, bus.req0_ready}, 0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check_val("ready_release", {bus.req1_ready, bus.req0_ready}, 0);
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        check_val("valid_after", bus.rsp_valid, 0);
        check_val("busy_after", bus.busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        p_vld[0] = 1'b0; p_vld[1] = 1'b0;
        p_a[0] = 8'd0; p_a[1] = 8'd0; p_b[0] = 8'd0; p_b[1] = 8'd0;
        bus.rsp_ready = 1'b0;
        drive();
        last_srv = 1;
        tick();
        tick();
        check_val("rst_valid", bus.rsp_valid, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_product", bus.rsp_product, 0);
        check_val("rst_id", bus.rsp_id, 0);
        reset = 1'b0;
        tick();

        // tie from reset, then rotation to requester 1
        p_vld[0] = 1'b1; p_a[0] = 8'd3; p_b[0] = 8'd5;
        p_vld[1] = 1'b1; p_a[1] = 8'd7; p_b[1] = 8'd9;
        do_txn(1, 1'b0);
        do_txn(0, 1'b0);

        p_vld[0] = 1'b1; p_a[0] = 8'd13; p_b[0] = 8'd11;
        do_txn(0, 1'b0);

        // max operands under backpressure with requester 1 arriving mid-flight
        p_vld[0] = 1'b1; p_a[0] = 8'd255; p_b[0] = 8'd255;
        do_txn(5, 1'b1);
        do_txn(0, 1'b0);

        p_vld[1] = 1'b1; p_a[1] = 8'd100; p_b[1] = 8'h03;
        do_txn(0, 1'b0);
        p_vld[0] = 1'b1; p_a[0] = 8'd77; p_b[0] = 8'h00;
        do_txn(0, 1'b0);

        // abort in RUN: no response may follow
        p_vld[0] = 1'b1; p_a[0] = 8'd200; p_b[0] = 8'd170;
        drive();
        tick();
        p_vld[0] = 1'b0;
        drive();
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check_val("abort_valid", bus.rsp_valid, 0);
        check_val("abort_busy", bus.busy, 0);
        check_val("abort_product", bus.rsp_product, 0);
        check_val("abort_id", bus.rsp_id, 0);
        tick();
        reset = 1'b0;
        last_srv = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_val("abort_no_rsp", {bus.busy, bus.rsp_valid}, 0);
        end

        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!p_vld[r] && ($urandom_range(0, 1) == 1)) new_req(r);
            end
            if (!p_vld[0] && !p_vld[1]) new_req($urandom_range(0, 1));
            do_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
